// File: rtl/md_unit_iter_if.sv
// ---------------------------------------------------------------------------
// md_unit_iter_if
// Request/status bundle between the EX stage / hazard unit (master) and the
// iterative multiply/divide unit (slave). Signal names follow the unit's
// architectural port names.
// ---------------------------------------------------------------------------
interface md_unit_iter_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             stall_req;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, A, B,
      input  busy, stall_req, hi, lo
   );

   modport slave (
      input  start, op, A, B,
      output busy, stall_req, hi, lo
   );
endinterface

// File: rtl/md_unit_iter.sv
// ---------------------------------------------------------------------------
// md_unit_iter
// Multi-cycle multiply/divide unit holding architectural HI/LO.
// MULT/MULTU/DIV/DIVU run for a fixed latency with busy asserted; MTHI/MTLO
// write in a single cycle. stall_req lets the hazard unit freeze ID from the
// accepting cycle until busy falls.
// Optional feature macro: MD_UNIT_MACC_EN enables MADD/MADDU/MSUB/MSUBU
// (ops 6..9); without it those codes are illegal and no accumulator adder
// is built.
// ---------------------------------------------------------------------------
module md_unit_iter #(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input logic           clk,
   input logic           reset_n,
   md_unit_iter_if.slave bus
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   localparam logic [CW-1:0]    MULT_CNT = CW'(MULT_LAT);
   localparam logic [CW-1:0]    DIV_CNT  = CW'(DIV_LAT);
   localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MTHI  = 4'd4;
   localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MD_UNIT_MACC_EN
   localparam logic [3:0] OP_MADD  = 4'd6;
   localparam logic [3:0] OP_MADDU = 4'd7;
   localparam logic [3:0] OP_MSUB  = 4'd8;
   localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Op classifies as multi-cycle (accepted into RUN)
   function automatic logic is_iter_op(input logic [3:0] o);
      logic r;
      case (o)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MD_UNIT_MACC_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Op treats its operands as two's complement
   function automatic logic is_signed_op(input logic [3:0] o);
      logic r;
      case (o)
         OP_MULT, OP_DIV: r = 1'b1;
`ifdef MD_UNIT_MACC_EN
         OP_MADD, OP_MSUB: r = 1'b1;
`endif
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Op uses the divide latency
   function automatic logic is_div_op(input logic [3:0] o);
      logic r;
      case (o)
         OP_DIV, OP_DIVU: r = 1'b1;
         default:         r = 1'b0;
      endcase
      return r;
   endfunction

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [3:0]         op_q;
   logic               busy_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic [2*WIDTH-1:0] a_ext_d;
   logic [2*WIDTH-1:0] b_ext_d;
   logic [2*WIDTH-1:0] prod_d;
   logic               a_neg_d;
   logic               b_neg_d;
   logic [WIDTH-1:0]   a_mag_d;
   logic [WIDTH-1:0]   b_mag_d;
   logic [WIDTH-1:0]   b_div_d;
   logic [WIDTH-1:0]   q_mag_d;
   logic [WIDTH-1:0]   r_mag_d;
   logic [WIDTH-1:0]   quo_d;
   logic [WIDTH-1:0]   rem_d;
   logic [2*WIDTH-1:0] res_d;
   logic               wr_d;

   // Operand extension and full-width product from the latched operands
   always_comb begin
      a_ext_d = {W_ZERO, a_q};
      b_ext_d = {W_ZERO, b_q};
      if (is_signed_op(op_q)) begin
         a_ext_d = {{WIDTH{a_q[WIDTH-1]}}, a_q};
         b_ext_d = {{WIDTH{b_q[WIDTH-1]}}, b_q};
      end else begin
         a_ext_d = {W_ZERO, a_q};
         b_ext_d = {W_ZERO, b_q};
      end
      prod_d = a_ext_d * b_ext_d;
   end

   // Sign-magnitude divide: quotient truncates toward zero, remainder takes
   // the dividend's sign. The magnitude form also covers MIN/-1 (quotient
   // magnitude 2^(WIDTH-1) reads back as MIN). A zero divisor is replaced
   // by one only to keep the datapath defined; its result is never written.
   always_comb begin
      a_neg_d = is_signed_op(op_q) & a_q[WIDTH-1];
      b_neg_d = is_signed_op(op_q) & b_q[WIDTH-1];
      if (a_neg_d) begin
         a_mag_d = ~a_q + W_ONE;
      end else begin
         a_mag_d = a_q;
      end
      if (b_neg_d) begin
         b_mag_d = ~b_q + W_ONE;
      end else begin
         b_mag_d = b_q;
      end
      if (b_mag_d == W_ZERO) begin
         b_div_d = W_ONE;
      end else begin
         b_div_d = b_mag_d;
      end
      q_mag_d = a_mag_d / b_div_d;
      r_mag_d = a_mag_d % b_div_d;
      if (a_neg_d ^ b_neg_d) begin
         quo_d = ~q_mag_d + W_ONE;
      end else begin
         quo_d = q_mag_d;
      end
      if (a_neg_d) begin
         rem_d = ~r_mag_d + W_ONE;
      end else begin
         rem_d = r_mag_d;
      end
   end

   // Select the {hi,lo} value committed at completion and whether to commit
   always_comb begin
      res_d = {hi_q, lo_q};
      wr_d  = 1'b0;
      case (op_q)
         OP_MULT, OP_MULTU: begin
            res_d = prod_d;
            wr_d  = 1'b1;
         end
         OP_DIV, OP_DIVU: begin
            res_d = {rem_d, quo_d};
            wr_d  = (b_q != W_ZERO);
         end
`ifdef MD_UNIT_MACC_EN
         OP_MADD, OP_MADDU: begin
            res_d = {hi_q, lo_q} + prod_d;
            wr_d  = 1'b1;
         end
         OP_MSUB, OP_MSUBU: begin
            res_d = {hi_q, lo_q} - prod_d;
            wr_d  = 1'b1;
         end
`endif
         default: begin
            res_d = {hi_q, lo_q};
            wr_d  = 1'b0;
         end
      endcase
   end

   // Control FSM: accepts ops in IDLE, counts latency in RUN, commits HI/LO
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= CNT_ZERO;
         a_q     <= W_ZERO;
         b_q     <= W_ZERO;
         op_q    <= 4'd0;
         busy_q  <= 1'b0;
         hi_q    <= W_ZERO;
         lo_q    <= W_ZERO;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  if (is_iter_op(bus.op)) begin
                     a_q     <= bus.A;
                     b_q     <= bus.B;
                     op_q    <= bus.op;
                     cnt_q   <= is_div_op(bus.op) ? DIV_CNT : MULT_CNT;
                     busy_q  <= 1'b1;
                     state_q <= S_RUN;
                  end else if (bus.op == OP_MTHI) begin
                     hi_q <= bus.A;
                  end else if (bus.op == OP_MTLO) begin
                     lo_q <= bus.A;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               // Requests arriving here are ignored; the stall holds them off
               cnt_q <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
                  if (wr_d) begin
                     hi_q <= res_d[2*WIDTH-1:WIDTH];
                     lo_q <= res_d[WIDTH-1:0];
                  end else begin
                     hi_q <= hi_q;
                  end
               end else begin
                  state_q <= S_RUN;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               cnt_q   <= CNT_ZERO;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   // Combinational so the hazard unit can freeze ID in the accepting cycle
   assign bus.stall_req = busy_q | (bus.start & is_iter_op(bus.op));

endmodule
